// File: rtl/row_scan_sequencer.sv
// Row-index sequencer for a 4-row Conway board: steps ROW_SEL 0..3 with a fixed dwell
// per row, honours STALL/ABORT, and pulses DONE while counting completed generations.
module row_scan_sequencer #(
  parameter int DWELL_CYCLES = 2,
  parameter int GEN_W        = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             STALL,
  input  logic             ABORT,
  output logic [1:0]       ROW_SEL,
  output logic             ROW_VALID,
  output logic             ROW_LAST,
  output logic             BUSY,
  output logic             DONE,
  output logic [GEN_W-1:0] GEN_COUNT,
  output logic [1:0]       STATE_DBG
);

  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       row_q, row_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic [GEN_W-1:0] gen_q, gen_d;

  // Handshake: START is a level sampled only in IDLE/DONE; STALL is an active-high
  // not-ready that freezes row and dwell in SCAN; ABORT outranks STALL.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    dwell_d = dwell_q;
    gen_d   = gen_q;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_SCAN;
          row_d   = 2'd0;
          dwell_d = '0;
        end
      end
      ST_SCAN: begin
        if (ABORT) begin
          state_d = ST_IDLE;
          row_d   = 2'd0;
          dwell_d = '0;
        end else if (!STALL) begin
          if (dwell_q != DWELL_LAST) begin
            dwell_d = dwell_q + DW'(1);
          end else if (row_q != 2'd3) begin
            row_d   = row_q + 2'd1;
            dwell_d = '0;
          end else begin
            // Count on entry so the new value is visible during the DONE cycle.
            state_d = ST_DONE;
            row_d   = 2'd0;
            dwell_d = '0;
            gen_d   = gen_q + GEN_W'(1);
          end
        end
      end
      ST_DONE: begin
        row_d   = 2'd0;
        dwell_d = '0;
        if (!ABORT && START) state_d = ST_SCAN;
        else                 state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        row_d   = 2'd0;
        dwell_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      row_q   <= 2'd0;
      dwell_q <= '0;
      gen_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      dwell_q <= dwell_d;
      gen_q   <= gen_d;
    end
  end

  // Outputs decode registered state only; no input reaches an output combinationally.
  assign ROW_SEL   = row_q;
  assign ROW_VALID = (state_q == ST_SCAN);
  assign ROW_LAST  = (state_q == ST_SCAN) && (row_q == 2'd3);
  assign BUSY      = (state_q == ST_SCAN) || (state_q == ST_DONE);
  assign DONE      = (state_q == ST_DONE);
  assign GEN_COUNT = gen_q;
  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_row_scan_sequencer.sv
// Directed bench for row_scan_sequencer: reset, basic scan, stall, START handling,
// abort/reset mid-scan, generation wrap, and a DWELL_CYCLES=1 instance.
module tb_row_scan_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start, stall, abort;
  logic       start1;
  logic       stall1, abort1;

  logic [1:0] row_sel, state_dbg;
  logic       row_valid, row_last, busy, done;
  logic [3:0] gen_count;

  logic [1:0] row_sel1, state_dbg1;
  logic       row_valid1, row_last1, busy1, done1;
  logic [3:0] gen_count1;

  logic [3:0] dec;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [3:0] exp_gen;

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  row_scan_sequencer #(.DWELL_CYCLES(2), .GEN_W(4)) u_dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .STALL(stall), .ABORT(abort),
    .ROW_SEL(row_sel), .ROW_VALID(row_valid), .ROW_LAST(row_last), .BUSY(busy),
    .DONE(done), .GEN_COUNT(gen_count), .STATE_DBG(state_dbg)
  );

  row_scan_sequencer #(.DWELL_CYCLES(1), .GEN_W(4)) u_dut1 (
    .CLK(clk), .RST_N(rst_n), .START(start1), .STALL(stall1), .ABORT(abort1),
    .ROW_SEL(row_sel1), .ROW_VALID(row_valid1), .ROW_LAST(row_last1), .BUSY(busy1),
    .DONE(done1), .GEN_COUNT(gen_count1), .STATE_DBG(state_dbg1)
  );

  // Downstream 2-to-4 decoder, gated by ROW_VALID, as the cell-update logic sees it
  assign dec = row_valid ? (4'b0001 << row_sel) : 4'b0000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".valid"}, 32'(row_valid), 32'd0);
    check({tag, ".sel"},   32'(row_sel),   32'd0);
    check({tag, ".last"},  32'(row_last),  32'd0);
    check({tag, ".busy"},  32'(busy),      32'd0);
    check({tag, ".done"},  32'(done),      32'd0);
    check({tag, ".gen"},   32'(gen_count), 32'(exp_gen));
    check({tag, ".state"}, 32'(state_dbg), 32'd0);
  endtask

  task automatic check_scan(input string tag, input logic [1:0] row);
    check({tag, ".valid"}, 32'(row_valid), 32'd1);
    check({tag, ".sel"},   32'(row_sel),   32'(row));
    check({tag, ".last"},  32'(row_last),  32'(row == 2'd3));
    check({tag, ".busy"},  32'(busy),      32'd1);
    check({tag, ".done"},  32'(done),      32'd0);
    check({tag, ".gen"},   32'(gen_count), 32'(exp_gen));
  endtask

  task automatic check_done(input string tag);
    check({tag, ".valid"}, 32'(row_valid), 32'd0);
    check({tag, ".sel"},   32'(row_sel),   32'd0);
    check({tag, ".busy"},  32'(busy),      32'd1);
    check({tag, ".done"},  32'(done),      32'd1);
    check({tag, ".gen"},   32'(gen_count), 32'(exp_gen));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; stall = 1'b0; abort = 1'b0;
    start1 = 1'b0; stall1 = 1'b0; abort1 = 1'b0;
    exp_gen = 4'd0;

    // 1. Reset held 2 edges with START asserted
    tick(); tick();
    check_idle("reset");
    rst_n = 1'b1; start = 1'b0;
    tick();
    check_idle("post_reset");

    // 2. Basic scan: rows 0..3 two cycles each, DONE at cycle 9, IDLE at 10
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      check_scan($sformatf("basic.c%0d", c), 2'((c - 1) / 2));
      tick();
    end
    exp_gen = 4'd1;
    check_done("basic.c9");
    tick();
    check_idle("basic.c10");

    // 3. Stall during row 1 (cycles 3-5): row 1 held 5 cycles, DONE at 12
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      logic [1:0] r;
      r = (c <= 2) ? 2'd0 : (c <= 7) ? 2'd1 : (c <= 9) ? 2'd2 : 2'd3;
      check_scan($sformatf("stall.c%0d", c), r);
      if (c >= 3 && c <= 7) check($sformatf("stall.val01.c%0d", c), 32'(dec), 32'h2);
      stall = (c >= 3 && c <= 5);
      tick();
    end
    stall = 1'b0;
    exp_gen = 4'd2;
    check_done("stall.c12");
    tick();
    check_idle("stall.c13");

    // 4a. START mid-scan ignored; 4b. START in DONE gives back-to-back scan
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      check_scan($sformatf("restart.c%0d", c), 2'((c - 1) / 2));
      start = (c == 4);
      tick();
    end
    start = 1'b0;
    exp_gen = 4'd3;
    check_done("restart.c9");
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 10; c <= 17; c++) begin
      check_scan($sformatf("b2b.c%0d", c), 2'((c - 10) / 2));
      tick();
    end
    exp_gen = 4'd4;
    check_done("b2b.c18");
    tick();
    check_idle("b2b.c19");

    // 5a. ABORT during row 2: IDLE next cycle, no DONE, GEN_COUNT kept
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      check_scan($sformatf("abort.c%0d", c), 2'((c - 1) / 2));
      if (c < 5) tick();
    end
    abort = 1'b1; tick(); abort = 1'b0;
    check_idle("abort.c6");
    tick();
    check_idle("abort.c7");

    // 5b. Reset during row 2: same, but GEN_COUNT cleared
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      check_scan($sformatf("rstmid.c%0d", c), 2'((c - 1) / 2));
      if (c < 5) tick();
    end
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    exp_gen = 4'd0;
    check_idle("rstmid.c6");
    tick();
    check_idle("rstmid.c7");

    // 6a. 16 complete scans: GEN_COUNT 1..15 then wraps to 0
    for (int s = 1; s <= 16; s++) begin
      start = 1'b1; tick(); start = 1'b0;
      for (int c = 1; c <= 8; c++) tick();
      exp_gen = 4'(s);
      check_done($sformatf("wrap.s%0d", s));
      tick();
    end
    check_idle("wrap.end");

    // 6b. DWELL_CYCLES=1: rows 0..3 in cycles 1-4, DONE at 5
    start1 = 1'b1; tick(); start1 = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("dw1.valid.c%0d", c), 32'(row_valid1), 32'd1);
      check($sformatf("dw1.sel.c%0d", c),   32'(row_sel1),   32'(c - 1));
      check($sformatf("dw1.last.c%0d", c),  32'(row_last1),  32'(c == 4));
      tick();
    end
    check("dw1.done.c5",  32'(done1),      32'd1);
    check("dw1.valid.c5", 32'(row_valid1), 32'd0);
    check("dw1.gen.c5",   32'(gen_count1), 32'd1);
    tick();
    check("dw1.busy.c6",  32'(busy1),      32'd0);
    check("dw1.done.c6",  32'(done1),      32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
